// File: rtl/mdu_iterative.sv
// mdu_iterative: iterative RV64 M-extension multiply/divide unit.
// Shift-add multiplier and restoring divider retire one result bit per cycle;
// one operation in flight, valid/ready on both request and response.
// Optional feature macro: MDU_WORD_OPS_EN enables the RV64 *W variants
// (MULW/DIVW/DIVUW/REMW/REMUW). Without it in_word is ignored.
module mdu_iterative #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic            in_word,
    input  logic [XLEN-1:0] in_src1,
    input  logic [XLEN-1:0] in_src2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(XLEN);

`ifdef MDU_WORD_OPS_EN
    localparam logic [CNT_W-1:0] CNT_WORD = CNT_W'(32);

    // Sign-extend a 32-bit word result to the full register width.
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction
`endif

    state_t                state_r;
    state_t                state_nxt_s;
    logic                  in_ready_r;
    logic                  out_valid_r;
    logic [XLEN-1:0]       out_result_r;
    logic [CNT_W-1:0]      counter_r;
    logic [2:0]            op_r;
    logic                  word_r;
    logic                  neg_q_r;     // negate product / quotient at the end
    logic                  neg_r_r;     // negate remainder at the end
    logic [XLEN-1:0]       a_r;         // multiplicand or divisor magnitude
    logic [2*XLEN-1:0]     prod_r;      // {hi, lo}: product, or {remainder, quotient}

    // Operand preparation (combinational, from the request port)
    logic                  word_s;
    logic                  signed1_s;
    logic                  signed2_s;
    logic [XLEN-1:0]       src1_s;
    logic [XLEN-1:0]       src2_s;
    logic                  s1_neg_s;
    logic                  s2_neg_s;
    logic [XLEN-1:0]       mag1_s;
    logic [XLEN-1:0]       mag2_s;
    logic [XLEN-1:0]       dividend_s;
    logic [XLEN-1:0]       min_s;
    logic                  div0_s;
    logic                  ovf_s;
    logic                  special_s;
    logic [CNT_W-1:0]      cnt_load_s;

    // Iteration and finalisation
    logic [XLEN:0]         mul_sum_s;
    logic [2*XLEN-1:0]     mul_next_s;
    logic [XLEN:0]         div_sub_s;
    logic [2*XLEN-1:0]     div_next_s;
    logic [2*XLEN-1:0]     mul_full_s;
    logic [XLEN-1:0]       quot_s;
    logic [XLEN-1:0]       rem_s;
    logic [XLEN-1:0]       fin_s;

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign out_result = out_result_r;

`ifndef MDU_WORD_OPS_EN
    logic [1:0] unused_word_s;
    assign unused_word_s = {in_word, word_r};
`endif

    // Decode the request: signedness, width, magnitudes and special cases
    always_comb begin
        word_s = 1'b0;
`ifdef MDU_WORD_OPS_EN
        word_s = in_word && !((in_op == 3'd1) || (in_op == 3'd2) || (in_op == 3'd3));
`endif
        signed1_s = (in_op == 3'd1) || (in_op == 3'd2) || (in_op == 3'd4) || (in_op == 3'd6);
        signed2_s = (in_op == 3'd1) || (in_op == 3'd4) || (in_op == 3'd6);
        src1_s    = in_src1;
        src2_s    = in_src2;
        min_s     = {1'b1, {(XLEN-1){1'b0}}};
        cnt_load_s = CNT_FULL;
`ifdef MDU_WORD_OPS_EN
        if (word_s) begin
            src1_s     = signed1_s ? sext32(in_src1[31:0]) : {{(XLEN-32){1'b0}}, in_src1[31:0]};
            src2_s     = signed2_s ? sext32(in_src2[31:0]) : {{(XLEN-32){1'b0}}, in_src2[31:0]};
            min_s      = {{(XLEN-31){1'b1}}, {31{1'b0}}};
            cnt_load_s = CNT_WORD;
        end else begin
            src1_s     = in_src1;
            src2_s     = in_src2;
        end
`endif
        s1_neg_s  = signed1_s && src1_s[XLEN-1];
        s2_neg_s  = signed2_s && src2_s[XLEN-1];
        mag1_s    = s1_neg_s ? ({XLEN{1'b0}} - src1_s) : src1_s;
        mag2_s    = s2_neg_s ? ({XLEN{1'b0}} - src2_s) : src2_s;
        dividend_s = mag1_s;
`ifdef MDU_WORD_OPS_EN
        // Park the 32-bit dividend at the top so 32 shifts consume all of it.
        if (word_s) begin
            dividend_s = {mag1_s[31:0], {(XLEN-32){1'b0}}};
        end else begin
            dividend_s = mag1_s;
        end
`endif
        div0_s    = in_op[2] && (src2_s == {XLEN{1'b0}});
        ovf_s     = ((in_op == 3'd4) || (in_op == 3'd6)) &&
                    (src1_s == min_s) && (src2_s == {XLEN{1'b1}});
        special_s = div0_s || ovf_s;
    end

    // One multiply (shift-add) or divide (restoring) step
    always_comb begin
        mul_sum_s  = {1'b0, prod_r[2*XLEN-1:XLEN]} +
                     (prod_r[0] ? {1'b0, a_r} : {(XLEN+1){1'b0}});
        mul_next_s = {mul_sum_s, prod_r[XLEN-1:1]};
        div_sub_s  = prod_r[2*XLEN-1:XLEN-1] - {1'b0, a_r};
        if (div_sub_s[XLEN]) begin
            div_next_s = {prod_r[2*XLEN-2:0], 1'b0};
        end else begin
            div_next_s = {div_sub_s[XLEN-1:0], prod_r[XLEN-2:0], 1'b1};
        end
    end

    // Sign correction and result selection, captured on the first DONE cycle
    always_comb begin
        mul_full_s = neg_q_r ? ({(2*XLEN){1'b0}} - prod_r) : prod_r;
        quot_s     = neg_q_r ? ({XLEN{1'b0}} - prod_r[XLEN-1:0]) : prod_r[XLEN-1:0];
        rem_s      = neg_r_r ? ({XLEN{1'b0}} - prod_r[2*XLEN-1:XLEN]) : prod_r[2*XLEN-1:XLEN];
        case (op_r)
            3'd0:                fin_s = mul_full_s[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    fin_s = mul_full_s[2*XLEN-1:XLEN];
            3'd4, 3'd5:          fin_s = quot_s;
            3'd6, 3'd7:          fin_s = rem_s;
            default:             fin_s = {XLEN{1'b0}};
        endcase
`ifdef MDU_WORD_OPS_EN
        if (word_r) begin
            // After 32 multiply steps the product sits XLEN-32 bits higher.
            if (op_r == 3'd0) begin
                fin_s = sext32(prod_r[XLEN-1:XLEN-32]);
            end else begin
                fin_s = sext32(fin_s[31:0]);
            end
        end else begin
            fin_s = fin_s;
        end
`endif
    end

    // Next-state logic; flush overrides any handshake
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (flush) begin
                    state_nxt_s = ST_IDLE;
                end else if (in_valid) begin
                    state_nxt_s = special_s ? ST_DONE : ST_CALC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (flush) begin
                    state_nxt_s = ST_IDLE;
                end else if (counter_r == CNT_ONE) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_CALC;
                end
            end
            ST_DONE: begin
                if (flush) begin
                    state_nxt_s = ST_IDLE;
                end else if (out_valid_r && out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register and registered request-side ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            in_ready_r <= 1'b1;
        end else begin
            state_r    <= state_nxt_s;
            in_ready_r <= (state_nxt_s == ST_IDLE);
        end
    end

    // Datapath: operand capture, iteration, result register and out_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r  <= 1'b0;
            out_result_r <= {XLEN{1'b0}};
            counter_r    <= {CNT_W{1'b0}};
            op_r         <= 3'd0;
            word_r       <= 1'b0;
            neg_q_r      <= 1'b0;
            neg_r_r      <= 1'b0;
            a_r          <= {XLEN{1'b0}};
            prod_r       <= {(2*XLEN){1'b0}};
        end else if (flush) begin
            out_valid_r  <= 1'b0;
            counter_r    <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_r   <= in_op;
                        word_r <= word_s;
                        if (special_s) begin
                            // Preload so the normal finalisation yields the fixed answer.
                            a_r       <= {XLEN{1'b0}};
                            neg_q_r   <= 1'b0;
                            neg_r_r   <= 1'b0;
                            counter_r <= {CNT_W{1'b0}};
                            prod_r    <= div0_s ? {src1_s, {XLEN{1'b1}}}
                                                : {{XLEN{1'b0}}, src1_s};
                        end else if (in_op[2]) begin
                            a_r       <= mag2_s;
                            neg_q_r   <= s1_neg_s ^ s2_neg_s;
                            neg_r_r   <= s1_neg_s;
                            counter_r <= cnt_load_s;
                            prod_r    <= {{XLEN{1'b0}}, dividend_s};
                        end else begin
                            a_r       <= mag1_s;
                            neg_q_r   <= s1_neg_s ^ s2_neg_s;
                            neg_r_r   <= 1'b0;
                            counter_r <= cnt_load_s;
                            prod_r    <= {{XLEN{1'b0}}, mag2_s};
                        end
                    end else begin
                        counter_r <= counter_r;
                    end
                end
                ST_CALC: begin
                    prod_r    <= op_r[2] ? div_next_s : mul_next_s;
                    counter_r <= counter_r - CNT_ONE;
                end
                ST_DONE: begin
                    if (!out_valid_r) begin
                        out_result_r <= fin_s;
                        out_valid_r  <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_r  <= 1'b0;
                    end else begin
                        out_valid_r  <= 1'b1;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iterative.sv
// Scoreboard bench for mdu_iterative: directed vectors push expected result
// and latency at accept; a negedge monitor pops and compares on out_valid.
module tb_mdu_iterative;

    localparam int XLEN = 64;

    typedef struct {
        logic [63:0] res;
        int          acc;
        int          lat;
        string       nm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  in_op = 3'd0;
    logic        in_word = 1'b0;
    logic [63:0] in_src1 = 64'd0;
    logic [63:0] in_src2 = 64'd0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b1;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] out_result;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t q[$];

    mdu_iterative #(.XLEN(XLEN), .CNT_W(7)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_word(in_word),
        .in_src1(in_src1), .in_src2(in_src2), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic check64(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Issue one request; optionally register its expected response.
    task automatic issue(input logic [2:0] op, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] res, input int lat,
                         input bit push, input string nm);
        int n;
        exp_t e;
        n = 0;
        while (!in_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) begin
            check64({nm, "_ready_timeout"}, 64'd0, 64'd1);
        end
        in_valid = 1'b1; in_op = op; in_word = w; in_src1 = a; in_src2 = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_src1 = 64'hA5A5_5A5A_DEAD_BEEF;   // later changes must not matter
        in_src2 = 64'h0123_4567_89AB_CDEF;
        if (push) begin
            e.res = res; e.acc = cyc; e.lat = lat; e.nm = nm;
            q.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q.size() != 0 || !in_ready || out_valid) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) begin
            check64("idle_timeout", 64'd0, 64'd1);
        end
    endtask

    // Monitor: pop at the first valid cycle, check latency, then check
    // the result on every valid cycle so a stall must keep it stable.
    initial begin
        bit   prev_valid, prev_hs, prev_flush, have;
        exp_t cur;
        prev_valid = 1'b0; prev_hs = 1'b0; prev_flush = 1'b0; have = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0; prev_hs = 1'b0; prev_flush = 1'b0; have = 1'b0;
            end else begin
                if (out_valid) begin
                    if (!prev_valid) begin
                        if (q.size() == 0) begin
                            have = 1'b0;
                            check64("unexpected_valid", 64'd1, 64'd0);
                        end else begin
                            cur  = q.pop_front();
                            have = 1'b1;
                            check64({cur.nm, "_latency"}, 64'(cyc - cur.acc), 64'(cur.lat));
                        end
                    end
                    if (have) begin
                        check64({cur.nm, "_result"}, out_result, cur.res);
                    end
                end else if (prev_valid && !prev_hs && !prev_flush) begin
                    check64("valid_dropped", 64'd0, 64'd1);
                end
                prev_valid = out_valid;
                prev_hs    = out_valid && out_ready;
                prev_flush = flush;
            end
        end
    end

    initial begin
        int n;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check64("reset_in_ready", 64'(in_ready), 64'd1);
        check64("reset_out_valid", 64'(out_valid), 64'd0);
        check64("reset_out_result", out_result, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65, 1, "mul_7x-3");
        issue(3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 65, 1, "mulhu_max");
        issue(3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 65, 1, "mulh_m1");
        issue(3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 65, 1, "mulhsu_m1");
        issue(3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 1, "div_-7/2");
        issue(3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 1, "rem_-7/2");
        issue(3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 65, 1, "divu_100/7");
        issue(3'd7, 1'b0, 64'd100, 64'd7, 64'd2, 65, 1, "remu_100/7");
        issue(3'd4, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 65, 1, "div_7/-2");
        issue(3'd6, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 65, 1, "rem_7/-2");
        issue(3'd4, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, "div_5/0");
        issue(3'd6, 1'b0, 64'd5, 64'd0, 64'd5, 1, 1, "rem_5/0");
        issue(3'd5, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, "divu_5/0");
        issue(3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1, 1, "div_ovf");
        issue(3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 1, "rem_ovf");
`ifdef MDU_WORD_OPS_EN
        issue(3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, 1, "divw_ovf");
        issue(3'd0, 1'b1, 64'h0000_0000_0001_0000, 64'h0000_0000_0001_0000, 64'd0, 33, 1, "mulw_wrap");
        issue(3'd0, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33, 1, "mulw_sext");
        issue(3'd6, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33, 1, "remw_-7/2");
        issue(3'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 65, 1, "mulh_word_ignored");
`else
        issue(3'd4, 1'b1, 64'h0000_0001_0000_0000, 64'd2, 64'h0000_0000_8000_0000, 65, 1, "div_word_ignored");
`endif
        wait_idle();

        // Stall in DONE: result must stay valid and stable for 5 cycles.
        out_ready = 1'b0;
        issue(3'd0, 1'b0, 64'h1234, 64'h10, 64'h12340, 65, 1, "mul_stall");
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (5) @(posedge clk);
        #1;
        check64("stall_valid_held", 64'(out_valid), 64'd1);
        check64("stall_result_held", out_result, 64'h12340);
        out_ready = 1'b1;
        wait_idle();

        // Flush 10 cycles into a DIV: the result never appears.
        issue(3'd5, 1'b0, 64'd1000, 64'd3, 64'd0, 0, 0, "div_flushed");
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(posedge clk); #1;
        check64("flush_in_ready", 64'(in_ready), 64'd1);
        check64("flush_out_valid", 64'(out_valid), 64'd0);
        repeat (80) @(posedge clk);
        #1;
        check64("flush_quiet", 64'(out_valid), 64'd0);

        // Reset mid-CALC returns to reset values immediately.
        issue(3'd5, 1'b0, 64'd1000, 64'd3, 64'd0, 0, 0, "div_reset");
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check64("midreset_in_ready", 64'(in_ready), 64'd1);
        check64("midreset_out_valid", 64'(out_valid), 64'd0);
        check64("midreset_out_result", out_result, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(3'd5, 1'b0, 64'd1000, 64'd3, 64'd333, 65, 1, "divu_after_reset");
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
